onehot_demux: RTL and testbench

Registered stream demultiplexer. It routes each beat on a single valid/ready input to exactly one of DEST_NUM outputs, chosen by a per-beat onehot destination vector. It sits on the fan-out side of shared datapaths, mirroring onehot-select multiplexing on the fan-in side. A two-entry buffer (output register plus skid register) gives full throughput with registered InReady. Beats with an illegal destination vector are consumed, dropped and counted.

---
 rtl/onehot_demux_pkg.sv | 23 ++
 rtl/onehot_demux_skid_buffer.sv | 96 +++++++++
 rtl/onehot_demux.sv | 74 +++++++
 tb/tb_onehot_demux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/onehot_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_demux_pkg
// Brief    : Shared FSM state and onehot legality check for onehot_demux.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_demux_pkg;

    localparam int C_MAX_DEST = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Exactly one bit set; narrower vectors are zero-extended by the caller.
    function automatic logic is_onehot(input logic [C_MAX_DEST-1:0] v);
        return (v != '0) && ((v & (v - C_MAX_DEST'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_demux_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : onehot_demux_skid_buffer
// Brief    : Two-entry valid/ready buffer (output + skid register) with
//            registered ready, carrying a {data, sel} beat.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_demux_skid_buffer
    import onehot_demux_pkg::*;
#(
    parameter type DATA_TYPE = logic,
    parameter int  DEST_NUM  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  DATA_TYPE            i_data,
    input  logic [DEST_NUM-1:0] i_sel,
    output logic                o_valid,
    output DATA_TYPE            o_data,
    output logic [DEST_NUM-1:0] o_sel,
    input  logic                i_pop
);

    typedef struct packed {
        DATA_TYPE            data;
        logic [DEST_NUM-1:0] sel;
    } beat_t;

    state_e r_state;
    beat_t  r_out;
    beat_t  r_skid;
    logic   r_valid;
    logic   r_ready;
    beat_t  w_in;
    logic   w_acc;
    logic   w_pop;

    assign w_in  = '{data: i_data, sel: i_sel};
    assign w_acc = i_valid && r_ready;
    assign w_pop = r_valid && i_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_acc) begin
                        r_out   <= w_in;
                        r_valid <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_ready <= 1'b1;
                    if (w_acc && !w_pop) begin
                        r_skid  <= w_in;
                        r_ready <= 1'b0;
                        r_state <= ST_FULL;
                    end else if (w_acc && w_pop) begin
                        r_out   <= w_in;
                    end else if (w_pop) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Ready is low here, so only a pop can move the state.
                    r_ready <= 1'b0;
                    if (w_pop) begin
                        r_out   <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_out.data;
    assign o_sel   = r_out.sel;

endmodule
`default_nettype wire

// File: rtl/onehot_demux.sv
`default_nettype none
// ============================================================================
// Module   : onehot_demux
// Brief    : Registered onehot-select stream demultiplexer with illegal-beat
//            drop, error pulse and saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_demux
    import onehot_demux_pkg::*;
#(
    parameter type DATA_TYPE = logic,
    parameter int  DEST_NUM  = 4,
    parameter int  CNT_W     = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                InValid,
    output logic                InReady,
    input  DATA_TYPE            InData,
    input  logic [DEST_NUM-1:0] InSel,
    output logic [DEST_NUM-1:0] OutValid,
    input  logic [DEST_NUM-1:0] OutReady,
    output DATA_TYPE            OutData,
    output logic                ErrPulse,
    output logic [CNT_W-1:0]    ErrCnt
);

    logic [C_MAX_DEST-1:0] w_sel_ext;
    logic                  w_legal;
    logic                  w_buf_valid;
    logic [DEST_NUM-1:0]   w_buf_sel;
    logic                  w_pop;
    logic                  r_err_pulse;
    logic [CNT_W-1:0]      r_err_cnt;

    assign w_sel_ext = C_MAX_DEST'(InSel);
    assign w_legal   = is_onehot(w_sel_ext);
    // Only the addressed destination's ready can release the beat.
    assign w_pop     = |(w_buf_sel & OutReady);

    onehot_demux_skid_buffer #(
        .DATA_TYPE (DATA_TYPE),
        .DEST_NUM  (DEST_NUM)
    ) u_skid_buffer (
        .clk     (Clk),
        .rst     (Rst),
        .i_valid (InValid && w_legal),
        .o_ready (InReady),
        .i_data  (InData),
        .i_sel   (InSel),
        .o_valid (w_buf_valid),
        .o_data  (OutData),
        .o_sel   (w_buf_sel),
        .i_pop   (w_pop)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= InValid && InReady && !w_legal;
            if (InValid && InReady && !w_legal && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign OutValid = {DEST_NUM{w_buf_valid}} & w_buf_sel;
    assign ErrPulse = r_err_pulse;
    assign ErrCnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_demux
// Brief    : Directed self-checking bench for onehot_demux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_demux;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       InValid;
    logic       InReady;
    logic [7:0] InData;
    logic [3:0] InSel;
    logic [3:0] OutValid;
    logic [3:0] OutReady;
    logic [7:0] OutData;
    logic       ErrPulse;
    logic [15:0] ErrCnt;

    logic       w2_in_ready;
    logic [3:0] w2_out_valid;
    logic [7:0] w2_out_data;
    logic       w2_err_pulse;
    logic [1:0] w2_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    onehot_demux #(.DATA_TYPE(logic [7:0]), .DEST_NUM(4), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .InData(InData), .InSel(InSel), .OutValid(OutValid),
        .OutReady(OutReady), .OutData(OutData), .ErrPulse(ErrPulse),
        .ErrCnt(ErrCnt)
    );

    onehot_demux #(.DATA_TYPE(logic [7:0]), .DEST_NUM(4), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(w2_in_ready),
        .InData(InData), .InSel(InSel), .OutValid(w2_out_valid),
        .OutReady(OutReady), .OutData(w2_out_data), .ErrPulse(w2_err_pulse),
        .ErrCnt(w2_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [7:0] data);
        InValid = v;
        InSel   = sel;
        InData  = data;
    endtask

    initial begin
        Rst = 1'b1; OutReady = 4'b0000;
        drive(1'b0, 4'b0000, 8'h00);
        step(); step();
        check("rst_outvalid", 32'(OutValid), 32'h0);
        check("rst_inready",  32'(InReady),  32'h0);
        check("rst_errpulse", 32'(ErrPulse), 32'h0);
        check("rst_errcnt",   32'(ErrCnt),   32'h0);
        Rst = 1'b0;
        step();
        check("rst_release_inready", 32'(InReady), 32'h1);

        // Single beat, latency one cycle
        OutReady = 4'b1111;
        drive(1'b1, 4'b0100, 8'hA5);
        step();
        drive(1'b0, 4'b0000, 8'h00);
        check("single_outvalid", 32'(OutValid), 32'h4);
        check("single_outdata",  32'(OutData),  32'hA5);
        check("single_inready",  32'(InReady),  32'h1);
        step();
        check("single_drained", 32'(OutValid), 32'h0);

        // Full-rate stream cycling destinations
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(1 << (i % 4)), 8'(8'h10 + i));
            step();
            check("stream_outvalid", 32'(OutValid), 32'(1 << (i % 4)));
            check("stream_outdata",  32'(OutData),  32'(8'h10 + i));
            check("stream_inready",  32'(InReady),  32'h1);
        end
        drive(1'b0, 4'b0000, 8'h00);
        step();
        check("stream_drained", 32'(OutValid), 32'h0);

        // Backpressure: two accepted, third held
        OutReady = 4'b0000;
        drive(1'b1, 4'b0001, 8'h31);
        step();
        check("bp_b0_valid",   32'(OutValid), 32'h1);
        check("bp_b0_inready", 32'(InReady),  32'h1);
        drive(1'b1, 4'b0010, 8'h32);
        step();
        check("bp_full_inready", 32'(InReady),  32'h0);
        check("bp_full_valid",   32'(OutValid), 32'h1);
        check("bp_full_data",    32'(OutData),  32'h31);
        drive(1'b1, 4'b0100, 8'h33);
        step(); step();
        check("bp_stall_inready", 32'(InReady),  32'h0);
        check("bp_stall_valid",   32'(OutValid), 32'h1);
        check("bp_stall_data",    32'(OutData),  32'h31);
        OutReady = 4'b1111;
        step();
        check("bp_rel_b1_valid",   32'(OutValid), 32'h2);
        check("bp_rel_b1_data",    32'(OutData),  32'h32);
        check("bp_rel_inready",    32'(InReady),  32'h1);
        step();
        drive(1'b0, 4'b0000, 8'h00);
        check("bp_rel_b2_valid", 32'(OutValid), 32'h4);
        check("bp_rel_b2_data",  32'(OutData),  32'h33);
        step();
        check("bp_drained", 32'(OutValid), 32'h0);

        // Illegal destinations
        drive(1'b1, 4'b0000, 8'h44);
        step();
        check("ill0_pulse",    32'(ErrPulse), 32'h1);
        check("ill0_cnt",      32'(ErrCnt),   32'h1);
        check("ill0_outvalid", 32'(OutValid), 32'h0);
        drive(1'b1, 4'b0110, 8'h45);
        step();
        check("ill1_pulse",    32'(ErrPulse), 32'h1);
        check("ill1_cnt",      32'(ErrCnt),   32'h2);
        check("ill1_outvalid", 32'(OutValid), 32'h0);
        drive(1'b0, 4'b0000, 8'h00);
        step();
        check("ill_pulse_end", 32'(ErrPulse),   32'h0);
        check("ill_cnt_hold",  32'(ErrCnt),     32'h2);
        check("ill_sat_cnt2",  32'(w2_err_cnt), 32'h2);
        drive(1'b1, 4'b1111, 8'h46);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, 4'b0000, 8'h00);
        step();
        check("ill_cnt7",     32'(ErrCnt),     32'h7);
        check("ill_sat_cnt3", 32'(w2_err_cnt), 32'h3);
        check("ill_no_out",   32'(OutValid),   32'h0);

        // Non-addressed ready ignored
        OutReady = 4'b1011;
        drive(1'b1, 4'b0100, 8'h55);
        step();
        drive(1'b0, 4'b0000, 8'h00);
        check("sel_pending_valid", 32'(OutValid), 32'h4);
        step(); step();
        check("sel_nopop_valid", 32'(OutValid), 32'h4);
        check("sel_nopop_data",  32'(OutData),  32'h55);
        OutReady = 4'b1111;
        step();
        check("sel_pop", 32'(OutValid), 32'h0);

        // Reset while FULL
        OutReady = 4'b0000;
        drive(1'b1, 4'b0001, 8'h61);
        step();
        drive(1'b1, 4'b1000, 8'h62);
        step();
        check("rf_full_inready", 32'(InReady), 32'h0);
        drive(1'b0, 4'b0000, 8'h00);
        Rst = 1'b1;
        step();
        check("rf_outvalid", 32'(OutValid), 32'h0);
        check("rf_inready",  32'(InReady),  32'h0);
        check("rf_errcnt",   32'(ErrCnt),   32'h0);
        Rst = 1'b0;
        step();
        check("rf_rel_inready",  32'(InReady),  32'h1);
        check("rf_rel_outvalid", 32'(OutValid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
